// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: NUM_CH-channel 134-bit packet aggregator. Whole-packet admission into
// per-channel FIFOs, packet-level round-robin onto a single registered output stream.

module pkt_rr_mux_ch #(
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 96,
    parameter int CNT_W         = 16,
    parameter int W             = 134
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_word,
    input  logic             rd_en,
    output logic [W-1:0]     rd_word,
    output logic             pkt_avail,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_HEAD, ACCEPT, DISCARD} in_st_t;

    in_st_t        st, st_nxt;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, last_ptr;
    logic [AW:0]   occ, pkt_cnt, free;
    logic          is_head, is_tail, admit, full;
    logic          wr_new, wr_over, drop_head, ovf, tail_wr, rd_tail;

    assign is_head   = in_word[W-2];
    assign is_tail   = in_word[W-1];
    assign free      = (AW+1)'(FIFO_DEPTH) - occ;
    assign admit     = free >= (AW+1)'(MAX_PKT_WORDS);
    assign full      = occ == (AW+1)'(FIFO_DEPTH);
    assign last_ptr  = wr_ptr - AW'(1);
    assign rd_word   = mem[rd_ptr];
    assign rd_tail   = rd_en & rd_word[W-1];
    assign pkt_avail = pkt_cnt != '0;

    always_comb begin
        st_nxt    = st;
        wr_new    = 1'b0;
        wr_over   = 1'b0;
        drop_head = 1'b0;
        ovf       = 1'b0;
        tail_wr   = 1'b0;
        if (in_valid) begin
            case (st)
                WAIT_HEAD: begin
                    if (is_head) begin
                        if (admit) begin
                            wr_new  = 1'b1;
                            tail_wr = is_tail;
                            if (!is_tail) st_nxt = ACCEPT;
                        end else begin
                            drop_head = 1'b1;
                            if (!is_tail) st_nxt = DISCARD;
                        end
                    end
                end
                ACCEPT: begin
                    // On overflow a tail replaces the last stored word so the packet still terminates.
                    if (!full) wr_new = 1'b1;
                    else begin
                        ovf     = 1'b1;
                        wr_over = is_tail;
                    end
                    tail_wr = is_tail;
                    if (is_tail) st_nxt = WAIT_HEAD;
                end
                DISCARD: begin
                    if (is_tail) st_nxt = WAIT_HEAD;
                end
                default: st_nxt = WAIT_HEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_new)       mem[wr_ptr]   <= in_word;
        else if (wr_over) mem[last_ptr] <= in_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= WAIT_HEAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            pkt_cnt    <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            ovf_err    <= 1'b0;
        end else begin
            st         <= st_nxt;
            wr_ptr     <= wr_ptr + AW'(wr_new);
            rd_ptr     <= rd_ptr + AW'(rd_en);
            occ        <= occ + (AW+1)'(wr_new) - (AW+1)'(rd_en);
            pkt_cnt    <= pkt_cnt + (AW+1)'(tail_wr) - (AW+1)'(rd_tail);
            drop_pulse <= drop_head;
            if (drop_head && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
            if (ovf) ovf_err <= 1'b1;
        end
    end
endmodule

module pkt_rr_mux #(
    parameter int NUM_CH        = 4,
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 96,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       data_in_valid,
    input  logic [NUM_CH*134-1:0]   data_in,
    output logic                    data_out_valid,
    output logic [133:0]            data_out,
    output logic [NUM_CH-1:0]       drop_pulse,
    output logic [NUM_CH*CNT_W-1:0] drop_cnt,
    output logic [NUM_CH-1:0]       ovf_err
);
    localparam int W    = 134;
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, SEND} out_st_t;

    out_st_t                  ost;
    logic [CH_W-1:0]          ptr, gnt, nxt_gnt, scan_idx;
    logic                     nxt_found;
    logic [NUM_CH-1:0]        rd_en, pkt_avail;
    logic [NUM_CH-1:0][W-1:0] rd_word;
    logic [W-1:0]             sel_word;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pkt_rr_mux_ch #(
            .FIFO_DEPTH   (FIFO_DEPTH),
            .MAX_PKT_WORDS(MAX_PKT_WORDS),
            .CNT_W        (CNT_W),
            .W            (W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (data_in_valid[k]),
            .in_word   (data_in[k*W +: W]),
            .rd_en     (rd_en[k]),
            .rd_word   (rd_word[k]),
            .pkt_avail (pkt_avail[k]),
            .drop_pulse(drop_pulse[k]),
            .drop_cnt  (drop_cnt[k*CNT_W +: CNT_W]),
            .ovf_err   (ovf_err[k])
        );
    end

    // Scan farthest-first so the nearest channel after ptr wins.
    always_comb begin
        nxt_found = 1'b0;
        nxt_gnt   = '0;
        scan_idx  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            scan_idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (pkt_avail[scan_idx]) begin
                nxt_found = 1'b1;
                nxt_gnt   = scan_idx;
            end
        end
    end

    always_comb begin
        rd_en = '0;
        if (ost == SEND) rd_en[gnt] = 1'b1;
    end

    assign sel_word = rd_word[gnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost            <= IDLE;
            ptr            <= CH_W'(NUM_CH - 1);
            gnt            <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            data_out_valid <= (ost == SEND);
            case (ost)
                IDLE: begin
                    if (nxt_found) begin
                        gnt <= nxt_gnt;
                        ost <= SEND;
                    end
                end
                SEND: begin
                    data_out <= sel_word;
                    if (sel_word[W-1]) begin
                        ptr <= gnt;
                        ost <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_rr_mux.sv
// Bench for pkt_rr_mux: directed scenarios plus randomized traffic, compared every
// cycle against a queue-based behavioural model of admission and round-robin output.

module tb_pkt_rr_mux;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 128;
    localparam int MAXW   = 96;
    localparam int CNT_W  = 16;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       data_in_valid;
    logic [NUM_CH*134-1:0]   data_in;
    logic                    data_out_valid;
    logic [133:0]            data_out;
    logic [NUM_CH-1:0]       drop_pulse;
    logic [NUM_CH*CNT_W-1:0] drop_cnt;
    logic [NUM_CH-1:0]       ovf_err;

    pkt_rr_mux #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_in_valid(data_in_valid), .data_in(data_in),
        .data_out_valid(data_out_valid), .data_out(data_out), .drop_pulse(drop_pulse),
        .drop_cnt(drop_cnt), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit gap_en  = 1'b0;
    int pid_ctr = 100;

    logic [133:0] txq [NUM_CH][$];
    int           last_tail_cyc [NUM_CH];
    logic [133:0] obs [$];
    int           obs_cyc [$];
    int           pulse_cnt [NUM_CH];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Word layout: tag, 4'hF, ch[7:0], pid[15:0], idx[15:0], 88 random bits.
    function automatic logic [133:0] mk(input logic [1:0] tag, input int ch, input int pid, input int idx);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {tag, 4'hF, 8'(ch), 16'(pid), 16'(idx), r[87:0]};
    endfunction

    task automatic push_pkt(input int ch, input int pid, input int len);
        logic [1:0] tag;
        for (int i = 0; i < len; i++) begin
            if (len == 1)          tag = 2'b11;
            else if (i == 0)       tag = 2'b01;
            else if (i == len - 1) tag = 2'b10;
            else                   tag = 2'b00;
            txq[ch].push_back(mk(tag, ch, pid, i));
        end
    endtask

    function automatic int cnt_pid(input int pid);
        int n = 0;
        for (int i = 0; i < obs.size(); i++) if (obs[i][119:104] == 16'(pid)) n++;
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Input driver: one word per channel per cycle from txq, optional random gaps.
    initial begin
        data_in_valid = '0;
        data_in       = '0;
        forever begin
            logic [NUM_CH-1:0]     v;
            logic [NUM_CH*134-1:0] d;
            logic [133:0]          w;
            @(posedge clk);
            #1;
            v = '0;
            d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (txq[k].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                    w = txq[k].pop_front();
                    v[k] = 1'b1;
                    d[k*134 +: 134] = w;
                    if (w[133]) last_tail_cyc[k] = cyc;
                end
            end
            data_in_valid = v;
            data_in       = d;
        end
    end

    // Behavioural model: per-channel word queues, complete packet = a tail present in the queue.
    localparam int S_WAIT = 0, S_ACC = 1, S_DIS = 2;
    logic [133:0]      mq [NUM_CH][$];
    int                mst [NUM_CH];
    int                m_dcnt [NUM_CH];
    logic [NUM_CH-1:0] m_ovf, m_pulse;
    bit                m_send;
    int                m_gnt, m_ptr;
    bit                m_vld;
    logic [133:0]      m_data;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            mq[k].delete();
            mst[k] = S_WAIT;
            m_dcnt[k] = 0;
        end
        m_ovf = '0; m_pulse = '0;
        m_send = 1'b0; m_gnt = 0; m_ptr = NUM_CH - 1;
        m_vld = 1'b0; m_data = '0;
    endtask

    task automatic model_step();
        int           pre [NUM_CH];
        bit           has_pkt [NUM_CH];
        logic [133:0] w;
        for (int k = 0; k < NUM_CH; k++) begin
            pre[k] = mq[k].size();
            has_pkt[k] = 1'b0;
            for (int i = 0; i < mq[k].size(); i++) if (mq[k][i][133]) has_pkt[k] = 1'b1;
        end
        m_vld = 1'b0;
        if (m_send) begin
            w = mq[m_gnt].pop_front();
            m_vld = 1'b1;
            m_data = w;
            if (w[133]) begin
                m_ptr = m_gnt;
                m_send = 1'b0;
            end
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                if (has_pkt[(m_ptr + i) % NUM_CH]) begin
                    m_gnt = (m_ptr + i) % NUM_CH;
                    m_send = 1'b1;
                    break;
                end
            end
        end
        m_pulse = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (data_in_valid[k]) begin
                w = data_in[k*134 +: 134];
                if (mst[k] == S_WAIT) begin
                    if (w[132]) begin
                        if (DEPTH - pre[k] >= MAXW) begin
                            mq[k].push_back(w);
                            if (!w[133]) mst[k] = S_ACC;
                        end else begin
                            m_pulse[k] = 1'b1;
                            if (m_dcnt[k] < (1 << CNT_W) - 1) m_dcnt[k]++;
                            if (!w[133]) mst[k] = S_DIS;
                        end
                    end
                end else if (mst[k] == S_ACC) begin
                    if (pre[k] < DEPTH) mq[k].push_back(w);
                    else begin
                        m_ovf[k] = 1'b1;
                        if (w[133]) mq[k][mq[k].size() - 1] = w;
                    end
                    if (w[133]) mst[k] = S_WAIT;
                end else begin
                    if (w[133]) mst[k] = S_WAIT;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle, DUT registered outputs vs model.
    initial forever begin
        @(negedge clk);
        check("out_valid", data_out_valid, m_vld);
        if (m_vld) check("out_data", data_out, m_data);
        check("drop_pulse", drop_pulse, m_pulse);
        check("ovf_err", ovf_err, m_ovf);
        for (int k = 0; k < NUM_CH; k++)
            check("drop_cnt", drop_cnt[k*CNT_W +: CNT_W], CNT_W'(m_dcnt[k]));
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (data_out_valid) begin
                obs.push_back(data_out);
                obs_cyc.push_back(cyc);
            end
            for (int k = 0; k < NUM_CH; k++) if (drop_pulse[k]) pulse_cnt[k]++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < NUM_CH; k++) txq[k].delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic gen_random(input int ch);
        int r, len;
        r = $urandom_range(0, 99);
        pid_ctr++;
        if (r < 5) begin
            txq[ch].push_back(mk(2'b00, ch, pid_ctr, 0));
            txq[ch].push_back(mk(2'b10, ch, pid_ctr, 1));
            return;
        end
        if (r < 60)      len = $urandom_range(1, 6);
        else if (r < 88) len = $urandom_range(7, 40);
        else if (r < 97) len = $urandom_range(41, 100);
        else             len = $urandom_range(110, 140);
        push_pkt(ch, pid_ctr, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int first31, last31;
        for (int k = 0; k < NUM_CH; k++) begin
            pulse_cnt[k] = 0;
            last_tail_cyc[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", data_out_valid, 0);
        check("rst_out_data", data_out, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_ovf_err", ovf_err, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 1) single 4-word packet on ch0
        obs.delete(); obs_cyc.delete();
        push_pkt(0, 1, 4);
        repeat (20) @(posedge clk);
        #2;
        check("t1_words", obs.size(), 4);
        if (obs.size() == 4) begin
            check("t1_head_lat", obs_cyc[0] - last_tail_cyc[0], 3);
            check("t1_contig", obs_cyc[3] - obs_cyc[0], 3);
            check("t1_head_tag", obs[0][133:132], 2'b01);
            check("t1_tail_tag", obs[3][133:132], 2'b10);
        end
        check("t1_drop_cnt", drop_cnt, 0);

        // 2) four single-word packets in the same cycle after reset
        do_reset();
        obs.delete(); obs_cyc.delete();
        for (int k = 0; k < NUM_CH; k++) push_pkt(k, 10 + k, 1);
        repeat (20) @(posedge clk);
        #2;
        check("t2_words", obs.size(), 4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_order", obs[i][127:120], i);
            for (int i = 0; i < 3; i++) check("t2_spacing", obs_cyc[i+1] - obs_cyc[i], 2);
        end

        // 3) ch1 holds 40 words while output is busy on ch0; next head dropped
        do_reset();
        obs.delete(); obs_cyc.delete();
        push_pkt(0, 20, 100);
        repeat (101) @(posedge clk);
        #2;
        push_pkt(1, 21, 40);
        push_pkt(1, 22, 7);
        repeat (300) @(posedge clk);
        #2;
        check("t3_drop_cnt1", drop_cnt[1*CNT_W +: CNT_W], 1);
        check("t3_pulse_cycles", pulse_cnt[1], 1);
        check("t3_dropped_words", cnt_pid(22), 0);
        check("t3_kept_words", cnt_pid(21), 40);
        check("t3_ch0_words", cnt_pid(20), 100);

        // 4) 130-word packet on ch2 overflows its FIFO
        obs.delete(); obs_cyc.delete();
        push_pkt(0, 30, 100);
        push_pkt(2, 31, 130);
        repeat (450) @(posedge clk);
        #2;
        check("t4_ovf", ovf_err, 4'b0100);
        check("t4_words", cnt_pid(31), 128);
        first31 = -1; last31 = -1;
        for (int i = 0; i < obs.size(); i++) if (obs[i][119:104] == 16'd31) begin
            if (first31 < 0) first31 = i;
            last31 = i;
        end
        if (first31 >= 0) begin
            check("t4_head_tag", obs[first31][133:132], 2'b01);
            check("t4_tail_tag", obs[last31][133:132], 2'b10);
            check("t4_tail_idx", obs[last31][103:88], 129);
        end

        // 5) headless body words on ch3
        obs.delete(); obs_cyc.delete();
        for (int i = 0; i < 4; i++) txq[3].push_back(mk(2'b00, 3, 40, i));
        txq[3].push_back(mk(2'b10, 3, 40, 4));
        repeat (20) @(posedge clk);
        #2;
        check("t5_out_words", obs.size(), 0);
        check("t5_pulse", pulse_cnt[3], 0);
        check("t5_drop_cnt3", drop_cnt[3*CNT_W +: CNT_W], 0);

        // 6) reset while ch0 packet is on the output
        do_reset();
        obs.delete(); obs_cyc.delete();
        push_pkt(0, 50, 20);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #2;
            if (cnt_pid(50) >= 3) got = 1'b1;
        end
        check("t6_inflight", got, 1);
        rst_n = 1'b0;
        for (int k = 0; k < NUM_CH; k++) txq[k].delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rst_valid", data_out_valid, 0);
            check("t6_rst_data", data_out, 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        obs.delete(); obs_cyc.delete();
        push_pkt(0, 51, 2);
        repeat (20) @(posedge clk);
        #2;
        check("t6_words", obs.size(), 2);
        check("t6_new_pkt", cnt_pid(51), 2);

        // randomized traffic against the model
        gap_en = 1'b1;
        obs.delete(); obs_cyc.delete();
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < NUM_CH; k++)
                if (txq[k].size() == 0 && $urandom_range(0, 19) == 0) gen_random(k);
        end
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(posedge clk);
            #2;
            got = (txq[0].size() + txq[1].size() + txq[2].size() + txq[3].size()) == 0;
        end
        check("rand_drained_input", got, 1);
        repeat (800) @(posedge clk);
        #2;
        check("rand_activity", obs.size() > 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
